// File: rtl/msx_audio_mixer.sv
// N-channel signed audio mixer: snapshot on sample_ce, sequential per-channel volume/mute
// accumulation, then saturation to OUT_W with sticky clip/overrun flags.
module msx_audio_mixer #(
   parameter int CHANNELS = 4,
   parameter int IN_W     = 16,
   parameter int VOL_W    = 4,
   parameter int OUT_W    = 16
) (
   input  logic                      clk21m,
   input  logic                      reset,
   input  logic                      sample_ce,
   input  logic [CHANNELS*IN_W-1:0]  ch_in,
   input  logic [CHANNELS*VOL_W-1:0] ch_vol,
   input  logic [CHANNELS-1:0]       ch_mute,
   input  logic                      clip_clr,
   output logic [OUT_W-1:0]          audio_out,
   output logic                      audio_valid,
   output logic                      busy,
   output logic                      clip,
   output logic                      overrun
);

   localparam int ACC_W = IN_W + VOL_W + $clog2(CHANNELS) + 1;
   localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CHANNELS - 1);
   localparam logic signed [ACC_W-1:0] ACC_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_SAT  = 2'd2
   } state_t;

   state_t                    state_q, state_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic signed [ACC_W-1:0]   acc_q, acc_d;
   logic [CHANNELS*IN_W-1:0]  snap_in_q, snap_in_d;
   logic [CHANNELS*VOL_W-1:0] snap_vol_q, snap_vol_d;
   logic [CHANNELS-1:0]       snap_mute_q, snap_mute_d;
   logic [OUT_W-1:0]          out_q, out_d;
   logic                      valid_q, valid_d;
   logic                      busy_q, busy_d;
   logic                      clip_q, clip_d;
   logic                      overrun_q, overrun_d;

   logic [IN_W-1:0]           cur_in_s;
   logic [VOL_W-1:0]          cur_vol_s;
   logic                      cur_mute_s;
   logic signed [ACC_W-1:0]   prod_s;
   logic signed [ACC_W-1:0]   term_s;
   logic                      sat_hi_s;
   logic                      sat_lo_s;
   logic [OUT_W-1:0]          sat_s;

   // Weighted term of the current channel and saturation of the running sum.
   always_comb begin
      cur_in_s   = snap_in_q[idx_q*IN_W +: IN_W];
      cur_vol_s  = snap_vol_q[idx_q*VOL_W +: VOL_W];
      cur_mute_s = snap_mute_q[idx_q];
      prod_s     = $signed({{(ACC_W-IN_W){cur_in_s[IN_W-1]}}, cur_in_s})
                 * $signed({{(ACC_W-VOL_W){1'b0}}, cur_vol_s});
      if (cur_mute_s) begin
         term_s = {ACC_W{1'b0}};
      end else begin
         term_s = prod_s >>> (VOL_W - 1);
      end
      sat_hi_s = (acc_q > ACC_MAX);
      sat_lo_s = (acc_q < ACC_MIN);
      if (sat_hi_s) begin
         sat_s = {1'b0, {(OUT_W-1){1'b1}}};
      end else if (sat_lo_s) begin
         sat_s = {1'b1, {(OUT_W-1){1'b0}}};
      end else begin
         sat_s = acc_q[OUT_W-1:0];
      end
   end

   // Sequencer next-state logic; flag sets override a same-cycle clear.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      acc_d       = acc_q;
      snap_in_d   = snap_in_q;
      snap_vol_d  = snap_vol_q;
      snap_mute_d = snap_mute_q;
      out_d       = out_q;
      valid_d     = 1'b0;
      busy_d      = busy_q;
      if (clip_clr) begin
         clip_d    = 1'b0;
         overrun_d = 1'b0;
      end else begin
         clip_d    = clip_q;
         overrun_d = overrun_q;
      end
      if (sample_ce && (state_q != S_IDLE)) begin
         overrun_d = 1'b1;
      end else begin
         overrun_d = overrun_d;
      end
      case (state_q)
         S_IDLE: begin
            busy_d = 1'b0;
            if (sample_ce) begin
               snap_in_d   = ch_in;
               snap_vol_d  = ch_vol;
               snap_mute_d = ch_mute;
               acc_d       = {ACC_W{1'b0}};
               idx_d       = {IDX_W{1'b0}};
               busy_d      = 1'b1;
               state_d     = S_ACC;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ACC: begin
            acc_d = acc_q + term_s;
            if (idx_q == IDX_LAST) begin
               idx_d   = {IDX_W{1'b0}};
               state_d = S_SAT;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = S_ACC;
            end
         end
         S_SAT: begin
            out_d   = sat_s;
            valid_d = 1'b1;
            state_d = S_IDLE;
            if (sat_hi_s || sat_lo_s) begin
               clip_d = 1'b1;
            end else begin
               clip_d = clip_d;
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk21m or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         idx_q       <= {IDX_W{1'b0}};
         acc_q       <= {ACC_W{1'b0}};
         snap_in_q   <= {(CHANNELS*IN_W){1'b0}};
         snap_vol_q  <= {(CHANNELS*VOL_W){1'b0}};
         snap_mute_q <= {CHANNELS{1'b0}};
         out_q       <= {OUT_W{1'b0}};
         valid_q     <= 1'b0;
         busy_q      <= 1'b0;
         clip_q      <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         acc_q       <= acc_d;
         snap_in_q   <= snap_in_d;
         snap_vol_q  <= snap_vol_d;
         snap_mute_q <= snap_mute_d;
         out_q       <= out_d;
         valid_q     <= valid_d;
         busy_q      <= busy_d;
         clip_q      <= clip_d;
         overrun_q   <= overrun_d;
      end
   end

   assign audio_out   = out_q;
   assign audio_valid = valid_q;
   assign busy        = busy_q;
   assign clip        = clip_q;
   assign overrun     = overrun_q;

endmodule
